// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared packet format and arbiter state encoding for the NoC router slice
package noc_pkg;

  localparam int DEST_W = 4;
  localparam int DATA_W = 7;
  localparam int PKT_W  = DEST_W + DATA_W;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_REL  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ack_sync.sv
// rtl/ack_sync.sv - multi-flop synchronizer bringing the link ack into the clk domain
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ack_async,
  output logic ack_s
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], ack_async};
    end
  end

  assign ack_s = sync_ff[STAGES-1];

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin arbiter sharing one output link, 4-phase req/ack transfer
module output_port_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int PKT_W       = noc_pkg::PKT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*PKT_W-1:0] in_pkt,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_req,
  output logic [PKT_W-1:0]         out_data,
  input  logic                     out_ack,
  output logic [2:0]               grant_id,
  output logic                     busy
);
  import noc_pkg::*;

  arb_state_t state;
  arb_state_t state_next;
  logic [2:0] rr_ptr;
  logic [2:0] winner;
  logic       ack_s;
  logic       accept;

  // First valid requester at or after ptr, wrapping around NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  ack_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack_async(out_ack),
    .ack_s    (ack_s)
  );

  always_comb begin
    winner     = rr_pick(in_valid, rr_ptr);
    accept     = (state == ARB_IDLE) && (|in_valid) && !ack_s;
    in_ready   = '0;
    state_next = state;
    if (accept) begin
      in_ready[winner] = 1'b1;
    end
    case (state)
      ARB_IDLE: if (accept) state_next = ARB_REQ;
      ARB_REQ:  if (ack_s)  state_next = ARB_REL;
      ARB_REL:  if (!ack_s) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state   <= state_next;
      out_req <= (state_next == ARB_REQ);
      // out_data only changes on acceptance, so it stays stable through the whole handshake
      if (accept) begin
        out_data <= in_pkt[int'(winner)*PKT_W +: PKT_W];
        grant_id <= winner;
        rr_ptr   <= (winner == 3'(NUM_REQ-1)) ? 3'd0 : winner + 3'd1;
      end
    end
  end

  assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - directed self-checking bench for output_port_arbiter
module tb_output_port_arbiter;

  localparam int NUM_REQ = 5;
  localparam int PKT_W   = 11;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*PKT_W-1:0] in_pkt;
  logic [NUM_REQ-1:0]       in_ready;
  logic                     out_req;
  logic [PKT_W-1:0]         out_data;
  logic                     out_ack;
  logic [2:0]               grant_id;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  output_port_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PKT_W(PKT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_pkt(in_pkt),
    .in_ready(in_ready),
    .out_req(out_req),
    .out_data(out_data),
    .out_ack(out_ack),
    .grant_id(grant_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input logic [PKT_W-1:0] v);
    in_pkt[i*PKT_W +: PKT_W] = v;
  endtask

  // Called one step after a rising edge with the FSM idle and inputs already driven.
  task automatic accept(input string tag, input logic [2:0] id, input logic [PKT_W-1:0] pkt,
                        input logic [NUM_REQ-1:0] rdy, input logic [NUM_REQ-1:0] clr,
                        input logic [NUM_REQ-1:0] set);
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    tick();
    check({tag, "_out_req"}, 32'(out_req), 32'd1);
    check({tag, "_out_data"}, 32'(out_data), 32'(pkt));
    check({tag, "_grant_id"}, 32'(grant_id), 32'(id));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready_req"}, 32'(in_ready), 32'd0);
    in_valid = (in_valid & ~clr) | set;
  endtask

  task automatic handshake(input string tag);
    int n;
    out_ack = 1'b1;
    n = 0;
    while (out_req && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_req_drop"}, 32'(out_req), 32'd0);
    out_ack = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    in_pkt   = '0;
    out_ack  = 1'b0;
    tick();
    tick();
    check("rst_out_req", 32'(out_req), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // single requester
    in_valid = 5'b00010;
    set_pkt(1, 11'h478);
    accept("single", 3'd1, 11'h478, 5'b00010, 5'b00010, 5'b00000);
    handshake("single");

    // all valid from reset: rr order 0..4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_REQ; i++) set_pkt(i, 11'(11'h100 + i));
    in_valid = 5'b11111;
    accept("all0", 3'd0, 11'h100, 5'b00001, 5'b00001, 5'b00000);
    handshake("all0");
    accept("all1", 3'd1, 11'h101, 5'b00010, 5'b00010, 5'b00000);
    handshake("all1");
    accept("all2", 3'd2, 11'h102, 5'b00100, 5'b00100, 5'b00000);
    handshake("all2");
    accept("all3", 3'd3, 11'h103, 5'b01000, 5'b01000, 5'b00000);
    handshake("all3");
    accept("all4", 3'd4, 11'h104, 5'b10000, 5'b10000, 5'b00000);
    handshake("all4");
    check("all_none_left", 32'(in_ready), 32'd0);

    // wrap: after grant to 4, rr_ptr is back at 0
    set_pkt(4, 11'h7F0);
    in_valid = 5'b10000;
    accept("wrap4", 3'd4, 11'h7F0, 5'b10000, 5'b10000, 5'b00000);
    handshake("wrap4");
    set_pkt(0, 11'h00F);
    set_pkt(4, 11'h7F1);
    in_valid = 5'b10001;
    accept("wrap0", 3'd0, 11'h00F, 5'b00001, 5'b00001, 5'b00000);
    handshake("wrap0");
    accept("wrap_rest4", 3'd4, 11'h7F1, 5'b10000, 5'b10000, 5'b00000);
    handshake("wrap_rest4");

    // fairness: 0 always valid, 3 raised during 0's transfer
    set_pkt(0, 11'h0AA);
    set_pkt(3, 11'h3CC);
    in_valid = 5'b00001;
    accept("fair0a", 3'd0, 11'h0AA, 5'b00001, 5'b00000, 5'b01000);
    handshake("fair0a");
    accept("fair3", 3'd3, 11'h3CC, 5'b01000, 5'b01000, 5'b00000);
    handshake("fair3");
    accept("fair0b", 3'd0, 11'h0AA, 5'b00001, 5'b00001, 5'b00000);
    handshake("fair0b");

    // delayed ack: request held with data stable and no acceptance
    set_pkt(2, 11'h2C5);
    set_pkt(4, 11'h4D2);
    in_valid = 5'b00100;
    accept("hold", 3'd2, 11'h2C5, 5'b00100, 5'b00100, 5'b10000);
    for (int c = 0; c < 10; c++) begin
      check("hold_out_req", 32'(out_req), 32'd1);
      check("hold_out_data", 32'(out_data), 32'h2C5);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    handshake("hold");

    // reset while out_req is high
    accept("pre_rst", 3'd4, 11'h4D2, 5'b10000, 5'b10000, 5'b00000);
    rst_n = 1'b0;
    #1;
    check("midrst_out_req", 32'(out_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    out_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    set_pkt(1, 11'h155);
    in_valid = 5'b00010;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("ackhi_in_ready", 32'(in_ready), 32'd0);
      check("ackhi_busy", 32'(busy), 32'd0);
      tick();
    end
    out_ack = 1'b0;
    tick();
    check("acklo_sync_ready", 32'(in_ready), 32'd0);
    tick();
    accept("post_rst", 3'd1, 11'h155, 5'b00010, 5'b00010, 5'b00000);
    handshake("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
